// File: rtl/srt_post_if.sv
// Port bundle for the SRT divider post-processing stage: divider-side inputs,
// the output valid/ready handshake and the status/statistics outputs.
interface srt_post_if #(
  parameter int unsigned WID = 8,
  parameter int unsigned SHW = $clog2(WID)
);
  localparam int unsigned LW = (SHW + 1 < 3) ? 3 : SHW + 1;

  logic           in_valid;
  logic [WID-1:0] in_rem_raw;
  logic [WID-1:0] in_quo_raw;
  logic [WID-1:0] in_div_n;
  logic [SHW-1:0] in_shamt;
  logic           in_dz;
  logic           out_valid;
  logic           out_ready;
  logic [WID-1:0] out_quo;
  logic [WID-1:0] out_rem;
  logic           out_dz;
  logic           ovf;
  logic           ovf_clr;
  logic [LW-1:0]  level;
  logic [15:0]    res_cnt;
  logic [15:0]    drop_cnt;

  modport master (
    output in_valid, in_rem_raw, in_quo_raw, in_div_n, in_shamt, in_dz, out_ready, ovf_clr,
    input  out_valid, out_quo, out_rem, out_dz, ovf, level, res_cnt, drop_cnt
  );

  modport slave (
    input  in_valid, in_rem_raw, in_quo_raw, in_div_n, in_shamt, in_dz, out_ready, ovf_clr,
    output out_valid, out_quo, out_rem, out_dz, ovf, level, res_cnt, drop_cnt
  );
endinterface

// File: rtl/srt_post.sv
// Radix-4 SRT post-processing: remainder correction, denormalize, output FIFO.
// Optional pop/drop counters are built when SRT_POST_STATS_EN is defined.
module srt_post #(
  parameter int unsigned WID   = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SHW   = $clog2(WID)
) (
  input  logic      clk,
  input  logic      rstn,
  srt_post_if.slave bus
);
  localparam int unsigned LW = (SHW + 1 < 3) ? 3 : SHW + 1;
  localparam int unsigned PW = $clog2(DEPTH);

  // Stage 1: correction
  logic           s1_valid_q;
  logic [WID-1:0] s1_rem_q, s1_rem_d, s1_quo_q, s1_quo_d;
  logic [SHW-1:0] s1_shamt_q;
  logic           s1_dz_q;
  // Stage 2: denormalize
  logic           s2_valid_q;
  logic [WID-1:0] s2_rem_q, s2_rem_d, s2_quo_q, s2_quo_d;
  logic           s2_dz_q;
  // FIFO
  logic [WID-1:0] quo_mem_q [DEPTH];
  logic [WID-1:0] rem_mem_q [DEPTH];
  logic           dz_mem_q  [DEPTH];
  logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           ovf_q, ovf_d;
  logic           full, out_valid, pop, wr_en, drop;

  always_comb begin
    s1_rem_d = bus.in_rem_raw;
    s1_quo_d = bus.in_quo_raw;
    // A negative remainder means the last digit overshot by one divisor.
    if (bus.in_rem_raw[WID-1]) begin
      s1_rem_d = bus.in_rem_raw + bus.in_div_n;
      s1_quo_d = bus.in_quo_raw - WID'(1);
    end
    s2_rem_d = s1_rem_q >> s1_shamt_q;
    s2_quo_d = s1_quo_q;
    if (s1_dz_q) begin
      s2_rem_d = '0;
      s2_quo_d = '1;
    end
  end

  assign full      = (level_q == LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign pop       = out_valid & bus.out_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign wr_en     = s2_valid_q & (~full | pop);
  assign drop      = s2_valid_q & full & ~pop;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (wr_en) wptr_d = wptr_q + PW'(1);
    if (pop)   rptr_d = rptr_q + PW'(1);
    if (wr_en && !pop)      level_d = level_q + LW'(1);
    else if (pop && !wr_en) level_d = level_q - LW'(1);
    ovf_d = ovf_q;
    if (drop)             ovf_d = 1'b1;
    else if (bus.ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_rem_q   <= '0;
      s1_quo_q   <= '0;
      s1_shamt_q <= '0;
      s1_dz_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_rem_q   <= '0;
      s2_quo_q   <= '0;
      s2_dz_q    <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_rem_q   <= s1_rem_d;
        s1_quo_q   <= s1_quo_d;
        s1_shamt_q <= bus.in_shamt;
        s1_dz_q    <= bus.in_dz;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_rem_q <= s2_rem_d;
        s2_quo_q <= s2_quo_d;
        s2_dz_q  <= s1_dz_q;
      end
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset; level gates everything read out of it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      quo_mem_q[wptr_q] <= s2_quo_q;
      rem_mem_q[wptr_q] <= s2_rem_q;
      dz_mem_q[wptr_q]  <= s2_dz_q;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_quo   = out_valid ? quo_mem_q[rptr_q] : '0;
  assign bus.out_rem   = out_valid ? rem_mem_q[rptr_q] : '0;
  assign bus.out_dz    = out_valid ? dz_mem_q[rptr_q]  : 1'b0;
  assign bus.ovf       = ovf_q;
  assign bus.level     = level_q;

`ifdef SRT_POST_STATS_EN
  logic [15:0] res_cnt_q, res_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    res_cnt_d  = res_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (pop && res_cnt_q != 16'hFFFF) res_cnt_d = res_cnt_q + 16'd1;
    if (drop) begin
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end else if (bus.ovf_clr) begin
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      res_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      res_cnt_q  <= res_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.res_cnt  = res_cnt_q;
  assign bus.drop_cnt = drop_cnt_q;
`else
  assign bus.res_cnt  = '0;
  assign bus.drop_cnt = '0;
`endif
endmodule

// File: doc/srt_post.md
Name: srt_post

Overview:
- Downstream post-processing stage for the radix-4 SRT divider pipeline.
- Consumes the divider's raw partial remainder and quotient, the normalized divisor and the leading-digit shift amount (all delayed to match the divider), and applies the negative-remainder correction.
- Denormalizes the remainder, flags divide-by-zero, and buffers results in a small FIFO with a valid/ready output handshake.
- The divider cannot stall, so the input side has no ready. Overflow is detected and reported, never back-pressured.

Parameters:
- WID, 8, operand/result width in bits.
- DEPTH, 4, output FIFO entries; power of two, at least 2.
- SHW, $clog2(WID), width of the shift-amount field.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- in_valid  in  1  a divider result is present this cycle.
- in_rem_raw  in  WID  raw final partial remainder; two's complement, normalized domain.
- in_quo_raw  in  WID  raw quotient from on-the-fly conversion.
- in_div_n  in  WID  normalized divisor matching this result.
- in_shamt  in  SHW  leading-digit shift amount applied to the divisor.
- in_dz  in  1  divisor was zero.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head.
- out_quo  out  WID  final quotient.
- out_rem  out  WID  final remainder.
- out_dz  out  1  divide-by-zero flag for the head entry.
- ovf  out  1  sticky overflow; a result was dropped.
- ovf_clr  in  1  clears ovf.
- level  out  SHW+1 (minimum 3)  FIFO occupancy.

Behaviour:
- Reset (synchronous, rstn low at posedge):
  - Clears both stage valids, FIFO pointers, level and ovf.
  - out_valid=0; out_quo, out_rem, out_dz = 0.
  - In-flight results are discarded. Inputs are ignored while rstn=0.
- Stage 1, correction register (S1), on in_valid:
  - If in_rem_raw[WID-1]=1: rem_c = in_rem_raw + in_div_n and quo_c = in_quo_raw - 1, both modulo 2^WID.
  - Otherwise rem_c = in_rem_raw and quo_c = in_quo_raw.
  - in_shamt and in_dz are registered alongside.
- Stage 2, denormalize register (S2):
  - rem_f = rem_c >> shamt, logical shift, zero fill.
  - If dz=1: quo_f = {WID{1'b1}} and rem_f = 0, regardless of raw data.
- FIFO write: S2 valid writes into the FIFO on the next posedge.
- Latency:
  - A result presented with in_valid at edge t is in S1 after t, in S2 after t+1, and written at t+2.
  - With the FIFO empty, out_valid=1 and data appear after edge t+2, i.e. 3 cycles.
- Throughput: one result per cycle.
- Handshake:
  - A pop occurs when out_valid & out_ready at a posedge.
  - out_* hold stable while out_valid=1 and out_ready=0.
  - out_ready is ignored when out_valid=0.
- Full:
  - A write when level=DEPTH and no pop in the same cycle drops the S2 result and sets ovf=1. The FIFO contents are unchanged.
  - A write and a pop in the same cycle while full both succeed; level stays DEPTH and ovf is not set.
- Empty: a write and no pop sets level 0 to 1. No pop can occur while empty.
- Pointers wrap modulo DEPTH. level is tracked separately: +1 on write-only, -1 on pop-only, unchanged on both.
- ovf:
  - Set has priority over ovf_clr in the same cycle.
  - Otherwise ovf_clr=1 clears it on the next edge.
  - Only rstn or ovf_clr clears it.

Optional Feature:
- Macro SRT_POST_STATS_EN.
- When defined, adds outputs:
  - res_cnt[15:0]: saturating count of pops.
  - drop_cnt[15:0]: saturating count of dropped results.
  - Both counters reset to 0 and hold at 16'hFFFF when saturated.
  - ovf_clr also clears drop_cnt.
- When undefined, both ports exist and are tied to 0, and no counter logic is built.

Test Plan:
- Positive result (WID=8): in_rem_raw=0x10, in_quo_raw=0x05, in_div_n=0x40, in_shamt=2, out_ready=1 -> after 3 cycles out_valid=1, out_quo=0x05, out_rem=0x04, out_dz=0.
- Negative correction: in_rem_raw=0xF0, in_quo_raw=0x05, in_div_n=0x40, in_shamt=1 -> out_quo=0x04, out_rem=0x18.
- Divide-by-zero: in_dz=1 with arbitrary data -> out_quo=0xFF, out_rem=0x00, out_dz=1.
- Backpressure and overflow (DEPTH=4): out_ready=0, six back-to-back results -> level=4, ovf=1 after the 5th write, first four results are popped in order once out_ready=1. Then pulse ovf_clr -> ovf=0. With SRT_POST_STATS_EN: drop_cnt=2, res_cnt=4.
- Full with simultaneous push/pop: level=4, out_ready=1, continuous in_valid -> level stays 4, ovf stays 0, outputs stream in order, one per cycle.
- Reset mid-operation: two results in the pipeline and three in the FIFO, rstn=0 for one edge -> out_valid=0, level=0, ovf=0, no stale result emitted afterwards.
